// File: rtl/param_processor.sv
// param_processor
//   Multicycle register-file CPU core. One shared memory port carries all
//   instruction, operand and data traffic using a request/acknowledge
//   handshake that tolerates any number of wait states. Adds Z/C flags,
//   BRZ/BRC conditional branches and a HALT / illegal-opcode trap.
//
// Ports
//   clk        clock, all state changes on rising edge
//   reset      synchronous, active-high
//   mem_rd     read request, held until mem_ack
//   mem_wr     write request, held until mem_ack
//   mem_addr   request address
//   mem_wdata  write data (valid while mem_wr=1)
//   mem_rdata  read data, sampled in the mem_ack cycle
//   mem_ack    completes the pending request this cycle
//   halted     core stopped (HALT or illegal opcode)
//   error      core stopped on an illegal opcode
//   pc         current program counter (debug)
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | read instruction word at PC
// DECODE  | run NOP/ALU/HALT, resolve branch condition, pick next path
// OPER    | read operand word at PC (branch target or data address)
// DATA    | RD: read mem[AR] into R[d]; WR: write R[s] to mem[AR]
// HALTED  | stopped, no requests, left only by reset

module param_processor #(
  parameter int                NREG     = 4,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              error,
  output logic [DATA_W-1:0] pc
);

  localparam int RSEL_W = $clog2(NREG);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_RD   = 4'd5;
  localparam logic [3:0] OP_WR   = 4'd6;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_BRZ  = 4'd8;
  localparam logic [3:0] OP_BRC  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_DATA,
    S_HALTED
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_ar;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic                r_z;
  logic                r_c;
  logic                r_error;

  logic [3:0]          w_op;
  logic [RSEL_W-1:0]   w_src;
  logic [RSEL_W-1:0]   w_dst;
  logic [DATA_W-1:0]   w_rs;
  logic [DATA_W-1:0]   w_rd;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_alu;
  logic                w_alu_c;

  logic                w_req_rd;
  logic                w_req_wr;
  logic [DATA_W-1:0]   w_req_addr;
  logic [DATA_W-1:0]   w_req_wdata;
  logic                w_ir_ld;
  logic                w_pc_inc;
  logic                w_pc_ld;
  logic                w_ar_ld;
  logic                w_alu_we;
  logic                w_mem_we;
  logic                w_err_set;

  assign w_op   = r_ir[DATA_W-1 -: 4];
  assign w_src  = r_ir[2*RSEL_W-1 : RSEL_W];
  assign w_dst  = r_ir[RSEL_W-1:0];
  assign w_rs   = r_regs[w_src];
  assign w_rd   = r_regs[w_dst];

  // The extra top bit gives carry-out for ADD and, for SUB, is set exactly
  // when R[d] < R[s] unsigned (the borrow).
  assign w_sum  = {1'b0, w_rd} + {1'b0, w_rs};
  assign w_diff = {1'b0, w_rd} - {1'b0, w_rs};

  always_comb begin
    w_alu   = '0;
    w_alu_c = 1'b0;
    case (w_op)
      OP_ADD:  begin w_alu = w_sum[DATA_W-1:0];  w_alu_c = w_sum[DATA_W];  end
      OP_SUB:  begin w_alu = w_diff[DATA_W-1:0]; w_alu_c = w_diff[DATA_W]; end
      OP_AND:  w_alu = w_rd & w_rs;
      OP_NOT:  w_alu = ~w_rs;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_req_rd    = 1'b0;
    w_req_wr    = 1'b0;
    w_req_addr  = '0;
    w_req_wdata = '0;
    w_ir_ld     = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_ld     = 1'b0;
    w_ar_ld     = 1'b0;
    w_alu_we    = 1'b0;
    w_mem_we    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req_rd   = 1'b1;
        w_req_addr = r_pc;
        if (mem_ack) begin
          w_ir_ld    = 1'b1;
          w_pc_inc   = 1'b1;
          w_state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_NOP:                         w_state_nx = S_FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
            w_alu_we   = 1'b1;
            w_state_nx = S_FETCH;
          end
          OP_RD, OP_WR, OP_BR:            w_state_nx = S_OPER;
          OP_BRZ, OP_BRC: begin
            if ((w_op == OP_BRZ) ? r_z : r_c) begin
              w_state_nx = S_OPER;
            end else begin
              // untaken: step over the target word
              w_pc_inc   = 1'b1;
              w_state_nx = S_FETCH;
            end
          end
          OP_HALT:                        w_state_nx = S_HALTED;
          default: begin
            w_err_set  = 1'b1;
            w_state_nx = S_HALTED;
          end
        endcase
      end
      S_OPER: begin
        w_req_rd   = 1'b1;
        w_req_addr = r_pc;
        if (mem_ack) begin
          if (w_op == OP_RD || w_op == OP_WR) begin
            w_ar_ld    = 1'b1;
            w_pc_inc   = 1'b1;
            w_state_nx = S_DATA;
          end else begin
            w_pc_ld    = 1'b1;
            w_state_nx = S_FETCH;
          end
        end
      end
      S_DATA: begin
        w_req_addr = r_ar;
        if (w_op == OP_WR) begin
          w_req_wr    = 1'b1;
          w_req_wdata = w_rs;
        end else begin
          w_req_rd    = 1'b1;
        end
        if (mem_ack) begin
          w_mem_we   = (w_op == OP_RD);
          w_state_nx = S_FETCH;
        end
      end
      S_HALTED: ;
      default:  w_state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_ar    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_error <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_ir_ld)       r_pc <= r_pc;
      if (w_pc_inc)      r_pc <= r_pc + DATA_W'(1);
      else if (w_pc_ld)  r_pc <= mem_rdata;
      if (w_ir_ld)       r_ir <= mem_rdata;
      if (w_ar_ld)       r_ar <= mem_rdata;
      if (w_alu_we) begin
        r_regs[w_dst] <= w_alu;
        r_z           <= (w_alu == '0);
        r_c           <= w_alu_c;
      end
      if (w_mem_we)      r_regs[w_dst] <= mem_rdata;
      if (w_err_set)     r_error <= 1'b1;
    end
  end

  // Requests are masked while reset is high so nothing can be issued or
  // completed in a reset cycle.
  assign mem_rd    = w_req_rd & ~reset;
  assign mem_wr    = w_req_wr & ~reset;
  assign mem_addr  = reset ? '0 : w_req_addr;
  assign mem_wdata = reset ? '0 : w_req_wdata;
  assign halted    = (r_state == S_HALTED);
  assign error     = r_error;
  assign pc        = r_pc;

endmodule

// File: doc/param_processor.md
# param_processor

Parametrised multicycle accumulator-free CPU core, next generation of the team's 8-bit bus-based processor. It generalises data width and register-file depth and adds three features: a ready/acknowledge memory handshake with arbitrary wait states, a carry flag with a BRC branch, and a HALT/illegal-opcode trap. It sits between the testbench/SoC memory model and nothing else; all instruction and data traffic uses one shared memory port.

## Interface
- DATA_W, 8: data, address and instruction width; must satisfy DATA_W >= 4 + 2*RSEL_W.
- NREG, 4: number of general registers; power of two, >= 2; RSEL_W = log2(NREG).
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mem_rd  out  1  read request; held until acknowledged.
- mem_wr  out  1  write request; held until acknowledged.
- mem_addr  out  DATA_W  request address.
- mem_wdata  out  DATA_W  write data; valid while mem_wr=1.
- mem_rdata  in  DATA_W  read data; sampled in the cycle mem_ack=1.
- mem_ack  in  1  completes the pending request in the same cycle; ignored when no request is pending.
- halted  out  1  core stopped (HALT or illegal opcode).
- error  out  1  stopped on illegal opcode.
- pc  out  DATA_W  current PC (debug).

## Operation
- Instruction word: opcode = IR[DATA_W-1 -: 4], src = IR[2*RSEL_W-1 : RSEL_W], dest = IR[RSEL_W-1:0]; other bits ignored.
- Opcodes: 0 NOP; 1 ADD R[d]<=R[d]+R[s]; 2 SUB R[d]<=R[d]-R[s]; 3 AND R[d]<=R[d]&R[s]; 4 NOT R[d]<=~R[s]; 5 RD R[d]<=mem[mem[PC]]; 6 WR mem[mem[PC]]<=R[s]; 7 BR PC<=mem[PC]; 8 BRZ (branch if Z); 9 BRC (branch if C); 15 HALT; 10-14 illegal.
- Flags (ALU ops only): Z = (result == 0) over DATA_W bits. C = carry-out for ADD, borrow (R[d] < R[s] unsigned) for SUB, 0 for AND/NOT. Non-ALU ops leave flags unchanged.
- All arithmetic modulo 2^DATA_W; PC increment wraps from 2^DATA_W-1 to 0.
- States:
  - FETCH: mem_rd=1, mem_addr=PC. On ack: IR<=mem_rdata, PC<=PC+1, go DECODE.
  - DECODE: NOP -> FETCH. ALU ops: write R[d], update Z/C, -> FETCH. RD/WR/BR -> OPER. BRZ/BRC: condition true -> OPER; false -> PC<=PC+1 (skip operand word), -> FETCH. HALT -> HALTED. Illegal -> HALTED, error<=1.
  - OPER: mem_rd=1, mem_addr=PC. On ack: BR/BRZ/BRC -> PC<=mem_rdata, -> FETCH; RD/WR -> AR<=mem_rdata, PC<=PC+1, -> DATA.
  - DATA: RD: mem_rd=1, mem_addr=AR; on ack R[d]<=mem_rdata, -> FETCH. WR: mem_wr=1, mem_addr=AR, mem_wdata=R[s]; on ack -> FETCH.
  - HALTED: no requests; halted=1; exits only on reset.
- Without ack, state and request outputs hold unchanged (address/data stable).
- mem_rd and mem_wr are never both 1.

## Timing
- Reset: state FETCH, PC=RESET_PC, IR/AR/all R=0, Z=C=0, halted=error=0. During a reset cycle mem_rd=mem_wr=0, mem_addr=mem_wdata=0; first fetch request appears the cycle after reset deasserts.
- Reset mid-operation has priority over any same-cycle ack: no register, flag or PC update; pending request dropped.
- Zero-wait memory (ack in request cycle): NOP/ALU/HALT 2 cycles; BRZ/BRC not taken 2; BR/taken branch 3; RD/WR 4. Each wait cycle on any access adds exactly 1.
- Register writes and flags visible to the next instruction's DECODE.

## Test plan
- ALU/flags, DATA_W=8: R0=0xFF, R1=0x01, ADD R1->R0 -> R0=0x00, Z=1, C=1; then SUB with R0=0x02, R1=0x03 -> R0=0xFF, Z=0, C=1; AND -> C=0.
- Memory ops with 3-cycle ack delay: RD at PC=0x10, operand 0x80, mem[0x80]=0x5A -> R2=0x5A, PC=0x12, addr/rd stable through waits; WR R2 to 0x81 -> one mem_wr with addr 0x81, wdata 0x5A.
- Branches: BRZ with Z=0 -> PC advances by 2, 2 cycles; BRZ with Z=1, operand 0x40 -> PC=0x40; BRC taken after ADD carry; PC=0xFF fetch wraps PC to 0x00.
- HALT/illegal: opcode 15 -> halted=1, error=0, no further requests for 20 cycles; opcode 0xA -> halted=1, error=1; reset -> both clear, fetch at RESET_PC.
- Reset during pending WR with ack asserted same cycle -> no write, all state at reset values.
- Parameter sweep DATA_W=16, NREG=8: ADD 0xFFFF+0x0001 into R7 -> 0x0000, Z=1, C=1; RD/WR across full 16-bit address.
